// File: rtl/drum_mult_pipe.sv
// Pipelined DRUM-style approximate (or per-transaction exact) unsigned multiplier.
// Latency 3 register stages; global stall: in_ready = !out_valid || out_ready, every stage holds when it is 0.
module drum_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int K     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_exact,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 out_exact
);
    localparam int PW = 2 * WIDTH;
    localparam int LW = $clog2(WIDTH);
    localparam int SW = $clog2(PW);

    generate
        if (WIDTH < 4 || WIDTH > 64 || K < 3 || K > WIDTH - 1) begin : g_bad_param
            $error("drum_mult_pipe: illegal WIDTH/K combination");
        end
    endgenerate

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             exact;
        logic [LW-1:0]    pa;
        logic [LW-1:0]    pb;
        logic             za;
        logic             zb;
    } s1_t;

    typedef struct packed {
        logic [K-1:0]  seg;
        logic [SW-1:0] sh;
    } seg_t;

    function automatic logic [LW-1:0] lead_one(input logic [WIDTH-1:0] x);
        logic [LW-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) r = LW'(i);
        end
        return r;
    endfunction

    // Operands below 2^K pass through untouched, which keeps small products exact.
    function automatic seg_t mk_seg(input logic [WIDTH-1:0] x, input logic [LW-1:0] p, input logic z);
        seg_t          r;
        logic [SW-1:0] sh;
        r  = '0;
        sh = SW'(p) - SW'(K - 1);
        if (z || (x >> K) == '0) begin
            r.seg = x[K-1:0];
            r.sh  = '0;
        end else begin
            r.seg = K'(x >> sh) | K'(1);
            r.sh  = sh;
        end
        return r;
    endfunction

    logic          advance;
    s1_t           s1_d, s1_q;
    logic          v1_q;
    seg_t          ga, gb;
    logic [PW-1:0] raw_d, raw_q;
    logic [SW-1:0] sh_d, sh_q;
    logic          ex2_q, v2_q;
    logic [PW-1:0] p_d, out_p_q;
    logic          out_valid_q, out_exact_q;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    always_comb begin
        s1_d       = '0;
        s1_d.a     = in_a;
        s1_d.b     = in_b;
        s1_d.exact = in_exact;
        s1_d.pa    = lead_one(in_a);
        s1_d.pb    = lead_one(in_b);
        s1_d.za    = (in_a == '0);
        s1_d.zb    = (in_b == '0);
    end

    always_comb begin
        ga    = mk_seg(s1_q.a, s1_q.pa, s1_q.za);
        gb    = mk_seg(s1_q.b, s1_q.pb, s1_q.zb);
        sh_d  = ga.sh + gb.sh;
        raw_d = s1_q.exact ? ({{WIDTH{1'b0}}, s1_q.a} * {{WIDTH{1'b0}}, s1_q.b})
                           : PW'({{K{1'b0}}, ga.seg} * {{K{1'b0}}, gb.seg});
    end

    always_comb begin
        p_d = ex2_q ? raw_q : (raw_q << sh_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            v1_q        <= 1'b0;
            raw_q       <= '0;
            sh_q        <= '0;
            ex2_q       <= 1'b0;
            v2_q        <= 1'b0;
            out_p_q     <= '0;
            out_exact_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            v1_q        <= in_valid;
            s1_q        <= s1_d;
            v2_q        <= v1_q;
            raw_q       <= raw_d;
            sh_q        <= sh_d;
            ex2_q       <= s1_q.exact;
            out_valid_q <= v2_q;
            // Bubbles leave the last result on out_p instead of loading garbage.
            if (v2_q) begin
                out_p_q     <= p_d;
                out_exact_q <= ex2_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_exact = out_exact_q;

endmodule

// File: tb/tb_drum_mult_pipe.sv
// Scoreboard bench for drum_mult_pipe at WIDTH=16, K=6.
module tb_drum_mult_pipe;
    localparam int W = 16;
    localparam int K = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            in_exact;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_p;
    logic            out_exact;

    always #5 clk = ~clk;

    drum_mult_pipe #(.WIDTH(W), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_exact  (in_exact),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_exact (out_exact)
    );

    typedef struct {
        logic [2*W-1:0] p;
        logic           e;
    } exp_t;

    exp_t sbq[$];
    exp_t pend;
    exp_t got_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vld_cnt = 0;
    int   run     = 0;
    int   max_run = 0;
    int   pops    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void seg(input logic [W-1:0] x, output logic [W-1:0] s, output int sh);
        int p;
        if (x < 64) begin
            s  = x;
            sh = 0;
        end else begin
            p = W - 1;
            while (!x[p]) p--;
            sh = p - (K - 1);
            s  = (x >> sh) | 16'd1;
        end
    endfunction

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic e);
        logic [W-1:0] sa, sb;
        int           ha, hb;
        if (e) return 32'(a) * 32'(b);
        seg(a, sa, ha);
        seg(b, sb, hb);
        return (32'(sa) * 32'(sb)) << (ha + hb);
    endfunction

    // Handshakes are sampled mid-cycle, so each one describes the transfer at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sbq.push_back(pend);
            if (out_valid) begin
                vld_cnt++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    got_e = sbq.pop_front();
                    chk("out_p", 64'(out_p), 64'(got_e.p));
                    chk("out_exact", 64'(out_exact), 64'(got_e.e));
                    pops++;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic e, input logic [2*W-1:0] p);
        int guard;
        guard    = 0;
        in_a     = a;
        in_b     = b;
        in_exact = e;
        pend.p   = p;
        pend.e   = e;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 50) begin
                chk("send_timeout", 64'(0), 64'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]   ra, rb;
        logic           re;
        logic [2*W-1:0] exp_a;
        int             p0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_exact  = 1'b0;
        out_ready = 1'b1;
        pend.p    = '0;
        pend.e    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_p", 64'(out_p), 64'(0));
        chk("rst_out_exact", 64'(out_exact), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'(1));

        // Latency: the capture edge is the first of three edges before out_valid.
        send(16'h0003, 16'h0005, 1'b0, 32'h0000000F);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("lat_edge2", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        chk("lat_edge3", 64'(out_valid), 64'(1));
        repeat (3) @(posedge clk);
        #1;

        send(16'hFFFF, 16'hFFFF, 1'b0, 32'hF8100000);
        send(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001);
        send(16'd1000, 16'd1,    1'b0, 32'h000003F0);
        send(16'h0000, 16'hFFFF, 1'b0, 32'h00000000);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        vld_cnt = 0;
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = (i == 2) ? 16'($urandom_range(0, 63)) : 16'($urandom);
            re = 1'((i % 3) == 0);
            send(ra, rb, re, model(ra, rb, re));
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("stream_vld_cnt", 64'(vld_cnt), 64'(8));
        chk("stream_run", 64'(max_run), 64'(8));

        out_ready = 1'b0;
        p0        = pops;
        ra        = 16'hABCD;
        rb        = 16'h1234;
        exp_a     = model(ra, rb, 1'b0);
        send(ra, rb, 1'b0, exp_a);
        send(16'h00FF, 16'h7F00, 1'b0, model(16'h00FF, 16'h7F00, 1'b0));
        send(16'h8001, 16'h0041, 1'b1, model(16'h8001, 16'h0041, 1'b1));
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            chk("stall_out_p", 64'(out_p), 64'(exp_a));
        end
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_count", 64'(pops - p0), 64'(3));
        chk("drain_empty", 64'(sbq.size()), 64'(0));

        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0));
        send(16'h3333, 16'h4444, 1'b1, model(16'h3333, 16'h4444, 1'b1));
        send(16'h5555, 16'h6666, 1'b0, model(16'h5555, 16'h6666, 1'b0));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out_p", 64'(out_p), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        sbq.delete();
        vld_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_stale", 64'(vld_cnt), 64'(0));

        p0 = pops;
        send(16'd1000, 16'd1, 1'b0, 32'h000003F0);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_result", 64'(pops - p0), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
